// File: rtl/dma2mem_trace_capture_if.sv
// Bus bundle for the DMA-to-memory trace capture engine.
// Carries the per-lane dma->memc write taps (observed only) and the merged
// valid/ready trace stream towards the result checker.
// The master side is the capture engine; the slave side is the surrounding
// fabric (lanes plus trace consumer).
interface dma2mem_trace_capture_if #(
  parameter int NUM_LANES = 32,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32,
  parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
);

  // Per-lane write port taps; lane l lives at [l*W +: W] of the flat vectors.
  logic [NUM_LANES-1:0]        lane_write_valid;
  logic [NUM_LANES-1:0]        lane_write_ready;
  logic [NUM_LANES*ADDR_W-1:0] lane_write_address;
  logic [NUM_LANES*DATA_W-1:0] lane_write_data;

  // Merged trace stream.
  logic                        trace_valid;
  logic                        trace_ready;
  logic [LANE_W-1:0]           trace_lane;
  logic [ADDR_W-1:0]           trace_address;
  logic [DATA_W-1:0]           trace_data;

  modport master (
    input  lane_write_valid,
    input  lane_write_ready,
    input  lane_write_address,
    input  lane_write_data,
    output trace_valid,
    input  trace_ready,
    output trace_lane,
    output trace_address,
    output trace_data
  );

  modport slave (
    output lane_write_valid,
    output lane_write_ready,
    output lane_write_address,
    output lane_write_data,
    input  trace_valid,
    output trace_ready,
    input  trace_lane,
    input  trace_address,
    input  trace_data
  );

endinterface

// File: rtl/dma2mem_trace_capture.sv
// Passive capture engine for DMA-to-memory write traffic in one PE.
// Every completed lane write (valid & ready) that passes the optional address
// window is parked in a one-entry per-lane holding register. A round-robin
// arbiter moves at most one held entry per cycle into a trace FIFO whose head
// is presented as a registered valid/ready stream. Writes that find their
// lane's holding register still occupied are lost and counted.
module dma2mem_trace_capture #(
  parameter int NUM_LANES  = 32,
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int DROP_CNT_W = 16,
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset_poweron,
  dma2mem_trace_capture_if.master  bus,
  input  logic                     capture_enable,
  input  logic                     filter_enable,
  input  logic [ADDR_W-1:0]        window_base,
  input  logic [ADDR_W-1:0]        window_limit,
  output logic [CNT_W-1:0]         fifo_count,
  output logic [DROP_CNT_W-1:0]    drop_count
);

  // Wide enough for the old count plus every lane dropping in one cycle,
  // with one spare bit to detect saturation.
  localparam int LANE_CNT_W = $clog2(NUM_LANES + 1);
  localparam int DSUM_W     = ((DROP_CNT_W > LANE_CNT_W) ? DROP_CNT_W : LANE_CNT_W) + 1;

  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Lane taps and fire qualification.
  logic [ADDR_W-1:0]    lane_addr [NUM_LANES];
  logic [DATA_W-1:0]    lane_data [NUM_LANES];
  logic [NUM_LANES-1:0] fire;
  logic [NUM_LANES-1:0] drop;

  // Holding registers.
  logic [NUM_LANES-1:0] hold_valid;
  logic [ADDR_W-1:0]    hold_addr [NUM_LANES];
  logic [DATA_W-1:0]    hold_data [NUM_LANES];

  // Arbiter.
  logic [LANE_W-1:0]    rr_ptr;
  logic [LANE_W-1:0]    grant_lane;
  logic                 grant_valid;
  logic [NUM_LANES-1:0] granted;
  logic                 can_push;

  // Drop accounting.
  logic [DSUM_W-1:0]     drop_sum;
  logic [DSUM_W-1:0]     drop_total;
  logic [DROP_CNT_W-1:0] drop_next;

  // Trace FIFO.
  entry_t               mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     rd_ptr_inc;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic [CNT_W-1:0]     count_next;
  entry_t               push_entry;
  entry_t               head_q;
  entry_t               head_next;
  logic                 trace_valid_q;
  logic                 valid_next;

  // Slice the flat lane buses and qualify each completed write.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic in_window;

    assign lane_addr[l] = bus.lane_write_address[l*ADDR_W +: ADDR_W];
    assign lane_data[l] = bus.lane_write_data[l*DATA_W +: DATA_W];
    // An inverted window (base > limit) can never satisfy both bounds.
    assign in_window    = (lane_addr[l] >= window_base) && (lane_addr[l] <= window_limit);
    assign fire[l]      = bus.lane_write_valid[l] & bus.lane_write_ready[l] & capture_enable &
                          (~filter_enable | in_window);
    // A lane whose register is being granted this cycle may reload it.
    assign drop[l]      = fire[l] & hold_valid[l] & ~granted[l];
  end

  // Round-robin search for the first occupied holding register from rr_ptr.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a variable unassigned and no latch is inferred.
    logic [LANE_W:0]   sum;
    logic [LANE_W-1:0] idx;
    grant_valid = 1'b0;
    grant_lane  = '0;
    granted     = '0;
    sum         = '0;
    idx         = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      sum = {1'b0, rr_ptr} + (LANE_W+1)'(i);
      if (sum >= (LANE_W+1)'(NUM_LANES)) begin
        sum = sum - (LANE_W+1)'(NUM_LANES);
      end
      idx = sum[LANE_W-1:0];
      if (!grant_valid && can_push && hold_valid[idx]) begin
        grant_valid  = 1'b1;
        grant_lane   = idx;
        granted[idx] = 1'b1;
      end
    end
  end

  // Pointer moves one past the granted lane; it holds when nothing is granted.
  always_ff @(posedge clk or posedge reset_poweron) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (reset_poweron) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_lane == LANE_W'(NUM_LANES - 1)) ? '0 : grant_lane + LANE_W'(1);
    end
  end

  // Load on an accepted fire, release on grant.
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      hold_valid <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        hold_addr[l] <= '0;
        hold_data[l] <= '0;
      end
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (fire[l] && !drop[l]) begin
          hold_valid[l] <= 1'b1;
          hold_addr[l]  <= lane_addr[l];
          hold_data[l]  <= lane_data[l];
        end else if (granted[l]) begin
          hold_valid[l] <= 1'b0;
        end
      end
    end
  end

  // Sum this cycle's drops and saturate the running total at all-ones.
  always_comb begin
    drop_sum = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      drop_sum = drop_sum + DSUM_W'(drop[l]);
    end
    drop_total = DSUM_W'(drop_count) + drop_sum;
    drop_next  = (|drop_total[DSUM_W-1:DROP_CNT_W]) ? '1 : drop_total[DROP_CNT_W-1:0];
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      drop_count <= '0;
    end else begin
      drop_count <= drop_next;
    end
  end

  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign pop        = trace_valid_q & bus.trace_ready;
  assign can_push   = ~fifo_full | pop;
  assign push       = grant_valid;
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);
  assign push_entry = '{lane: grant_lane, addr: hold_addr[grant_lane], data: hold_data[grant_lane]};

  // Next occupancy and next head; the head only changes on a pop or when an
  // empty FIFO receives its first entry, so it is stable under backpressure.
  always_comb begin
    count_next = fifo_count;
    if (push && !pop) begin
      count_next = fifo_count + CNT_W'(1);
    end else if (!push && pop) begin
      count_next = fifo_count - CNT_W'(1);
    end

    head_next = head_q;
    if (count_next == '0) begin
      head_next = '0;
    end else if (pop) begin
      head_next = (fifo_count == CNT_W'(1)) ? push_entry : mem[rd_ptr_inc];
    end else if (fifo_count == '0) begin
      head_next = push_entry;
    end
    valid_next = (count_next != '0);
  end

  // FIFO pointers, occupancy and registered head.
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      head_q        <= '0;
      trace_valid_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      fifo_count    <= count_next;
      head_q        <= head_next;
      trace_valid_q <= valid_next;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is left unreset; occupancy and pointers alone decide
    // which entries are meaningful, so clearing the array buys nothing.
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  assign bus.trace_valid   = trace_valid_q;
  assign bus.trace_lane    = head_q.lane;
  assign bus.trace_address = head_q.addr;
  assign bus.trace_data    = head_q.data;

endmodule

// File: tb/tb_dma2mem_trace_capture.sv
// Self-checking bench for dma2mem_trace_capture.
// Expected trace entries go into a scoreboard queue when a write is driven and
// are compared as the trace stream hands them out. Filter/enable corner cases
// come from a vector table; latency, backpressure, saturation and reset are
// hand-written sequences.
`timescale 1ns/1ps
module tb_dma2mem_trace_capture;

  localparam int NUM_LANES  = 32;
  localparam int ADDR_W     = 24;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 16;
  localparam int DROP_CNT_W = 16;
  localparam int CNT_W      = 5;

  logic                  clk = 1'b0;
  logic                  reset_poweron;
  logic                  capture_enable;
  logic                  filter_enable;
  logic [ADDR_W-1:0]     window_base;
  logic [ADDR_W-1:0]     window_limit;
  logic [CNT_W-1:0]      fifo_count;
  logic [DROP_CNT_W-1:0] drop_count;

  dma2mem_trace_capture_if #(.NUM_LANES(NUM_LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dma2mem_trace_capture #(
    .NUM_LANES (NUM_LANES),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .DROP_CNT_W(DROP_CNT_W)
  ) dut (
    .clk           (clk),
    .reset_poweron (reset_poweron),
    .bus           (bus),
    .capture_enable(capture_enable),
    .filter_enable (filter_enable),
    .window_base   (window_base),
    .window_limit  (window_limit),
    .fifo_count    (fifo_count),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  lane;
    logic [23:0] addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    string       name;
    int          lane;
    logic [23:0] addr;
    logic [31:0] data;
    logic        lane_ready;
    logic        cap_en;
    logic        filt_en;
    logic [23:0] base;
    logic [23:0] limit;
    logic        traced;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[11];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic clear_lanes();
    bus.lane_write_valid   = '0;
    bus.lane_write_ready   = '0;
    bus.lane_write_address = '0;
    bus.lane_write_data    = '0;
  endtask

  task automatic set_lane(input int l, input logic [23:0] a, input logic [31:0] d);
    bus.lane_write_valid[l]                   = 1'b1;
    bus.lane_write_ready[l]                   = 1'b1;
    bus.lane_write_address[l*ADDR_W +: ADDR_W] = a;
    bus.lane_write_data[l*DATA_W +: DATA_W]    = d;
  endtask

  task automatic push_exp(input int l, input logic [23:0] a, input logic [31:0] d);
    exp_t e;
    e.lane = 5'(l);
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_poweron = 1'b1;
    clear_lanes();
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset_poweron = 1'b0;
  endtask

  // Wait (bounded) until every expected entry has come out, then confirm the FIFO is empty.
  task automatic wait_drain(input string name, input int budget);
    int cyc = 0;
    while (sb_q.size() != 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_drained"}, 64'(sb_q.size()), 64'(0));
    @(negedge clk);
    check({name, "_fifo_empty"}, 64'(fifo_count), 64'(0));
  endtask

  // Scoreboard side: every accepted head must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (bus.trace_valid === 1'b1 && bus.trace_ready === 1'b1) begin
      check("sb_entry_expected", 64'(sb_q.size() != 0), 64'(1));
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_lane", 64'(bus.trace_lane), 64'(e.lane));
        check("sb_addr", 64'(bus.trace_address), 64'(e.addr));
        check("sb_data", 64'(bus.trace_data), 64'(e.data));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{"below_base",      1, 24'h000FFF, 32'h1111_0001, 1'b1, 1'b1, 1'b1, 24'h001000, 24'h001FFF, 1'b0};
    vecs[1]  = '{"at_base",         2, 24'h001000, 32'h1111_0002, 1'b1, 1'b1, 1'b1, 24'h001000, 24'h001FFF, 1'b1};
    vecs[2]  = '{"at_limit",        3, 24'h001FFF, 32'h1111_0003, 1'b1, 1'b1, 1'b1, 24'h001000, 24'h001FFF, 1'b1};
    vecs[3]  = '{"above_limit",     4, 24'h002000, 32'h1111_0004, 1'b1, 1'b1, 1'b1, 24'h001000, 24'h001FFF, 1'b0};
    vecs[4]  = '{"filter_off",      5, 24'h002000, 32'h1111_0005, 1'b1, 1'b1, 1'b0, 24'h001000, 24'h001FFF, 1'b1};
    vecs[5]  = '{"inverted_window", 6, 24'h002800, 32'h1111_0006, 1'b1, 1'b1, 1'b1, 24'h003000, 24'h002000, 1'b0};
    vecs[6]  = '{"single_addr_win", 7, 24'h004444, 32'h1111_0007, 1'b1, 1'b1, 1'b1, 24'h004444, 24'h004444, 1'b1};
    vecs[7]  = '{"capture_off",     8, 24'h001500, 32'h1111_0008, 1'b1, 1'b0, 1'b1, 24'h001000, 24'h001FFF, 1'b0};
    vecs[8]  = '{"lane_not_ready",  9, 24'h001500, 32'h1111_0009, 1'b0, 1'b1, 1'b1, 24'h001000, 24'h001FFF, 1'b0};
    vecs[9]  = '{"top_lane_max",   31, 24'hFFFFFF, 32'h1111_001F, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h000000, 1'b1};
    vecs[10] = '{"full_window",     0, 24'h000000, 32'h1111_0000, 1'b1, 1'b1, 1'b1, 24'h000000, 24'hFFFFFF, 1'b1};

    reset_poweron   = 1'b1;
    capture_enable  = 1'b1;
    filter_enable   = 1'b0;
    window_base     = '0;
    window_limit    = '0;
    bus.trace_ready = 1'b0;
    clear_lanes();
    repeat (2) @(negedge clk);
    reset_poweron = 1'b0;

    // Reset state: all outputs zero.
    @(negedge clk);
    check("rst_trace_valid", 64'(bus.trace_valid), 64'(0));
    check("rst_trace_lane", 64'(bus.trace_lane), 64'(0));
    check("rst_trace_addr", 64'(bus.trace_address), 64'(0));
    check("rst_trace_data", 64'(bus.trace_data), 64'(0));
    check("rst_fifo_count", 64'(fifo_count), 64'(0));
    check("rst_drop_count", 64'(drop_count), 64'(0));

    // Single write on lane 3: visible two cycles after the fire, stable under backpressure.
    do_reset();
    bus.trace_ready = 1'b0;
    @(negedge clk);
    set_lane(3, 24'h000100, 32'hDEADBEEF);
    push_exp(3, 24'h000100, 32'hDEADBEEF);
    @(negedge clk);
    clear_lanes();
    check("t1_not_yet_valid", 64'(bus.trace_valid), 64'(0));
    @(negedge clk);
    check("t1_valid", 64'(bus.trace_valid), 64'(1));
    check("t1_lane", 64'(bus.trace_lane), 64'(3));
    check("t1_addr", 64'(bus.trace_address), 64'(24'h000100));
    check("t1_data", 64'(bus.trace_data), 64'(32'hDEADBEEF));
    check("t1_count", 64'(fifo_count), 64'(1));
    @(negedge clk);
    check("t1_hold_valid", 64'(bus.trace_valid), 64'(1));
    check("t1_hold_data", 64'(bus.trace_data), 64'(32'hDEADBEEF));
    bus.trace_ready = 1'b1;
    wait_drain("t1", 10);

    // All lanes fire together: drained in lane order 0..31, one per cycle, no drops.
    do_reset();
    bus.trace_ready = 1'b1;
    @(negedge clk);
    for (int l = 0; l < NUM_LANES; l++) begin
      set_lane(l, 24'h100000 + 24'(l), 32'hA500_0000 + 32'(l));
      push_exp(l, 24'h100000 + 24'(l), 32'hA500_0000 + 32'(l));
    end
    @(negedge clk);
    clear_lanes();
    repeat (3) @(negedge clk);
    check("t2_one_in_one_out", 64'(fifo_count), 64'(1));
    wait_drain("t2", 60);
    check("t2_drops", 64'(drop_count), 64'(0));

    // Vector table: address window, enables and lane handshake qualification.
    // capture_enable drops right after each fire, so traced entries also show
    // that held entries still drain while capture is disabled.
    do_reset();
    bus.trace_ready = 1'b1;
    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      capture_enable = vecs[v].cap_en;
      filter_enable  = vecs[v].filt_en;
      window_base    = vecs[v].base;
      window_limit   = vecs[v].limit;
      set_lane(vecs[v].lane, vecs[v].addr, vecs[v].data);
      bus.lane_write_ready[vecs[v].lane] = vecs[v].lane_ready;
      if (vecs[v].traced) push_exp(vecs[v].lane, vecs[v].addr, vecs[v].data);
      @(negedge clk);
      clear_lanes();
      capture_enable = 1'b0;
      repeat (3) @(negedge clk);
      check({vecs[v].name, "_sb"}, 64'(sb_q.size()), 64'(0));
    end
    capture_enable = 1'b1;
    filter_enable  = 1'b0;
    check("t4_drops", 64'(drop_count), 64'(0));
    check("t4_fifo_empty", 64'(fifo_count), 64'(0));

    // Multi-lane drops and saturation: every lane fires every cycle with no consumer.
    do_reset();
    bus.trace_ready = 1'b0;
    @(negedge clk);
    for (int l = 0; l < NUM_LANES; l++) set_lane(l, 24'(l), 32'(l));
    repeat (3) @(negedge clk);
    check("sat_two_cycles_drops", 64'(drop_count), 64'(62));
    repeat (2200) @(negedge clk);
    check("sat_saturated", 64'(drop_count), 64'(16'hFFFF));
    check("sat_fifo_full", 64'(fifo_count), 64'(16));
    clear_lanes();

    // Full FIFO with simultaneous push and pop: count pinned at 16, order kept.
    do_reset();
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      set_lane(5, 24'h005000 + 24'(i), 32'h5500_0000 + 32'(i));
      push_exp(5, 24'h005000 + 24'(i), 32'h5500_0000 + 32'(i));
    end
    for (int i = 17; i < 27; i++) begin
      @(negedge clk);
      bus.trace_ready = 1'b1;
      check("t5_full_count", 64'(fifo_count), 64'(16));
      set_lane(5, 24'h005000 + 24'(i), 32'h5500_0000 + 32'(i));
      push_exp(5, 24'h005000 + 24'(i), 32'h5500_0000 + 32'(i));
    end
    @(negedge clk);
    clear_lanes();
    check("t5_full_count_last", 64'(fifo_count), 64'(16));
    wait_drain("t5", 40);
    check("t5_drops", 64'(drop_count), 64'(0));

    // Backpressure: 20 back-to-back writes on lane 0 -> 16 queued, 1 held, 3 dropped.
    do_reset();
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      set_lane(0, 24'h002000 + 24'(i), 32'h3000_0000 + 32'(i));
      if (i < 17) push_exp(0, 24'h002000 + 24'(i), 32'h3000_0000 + 32'(i));
    end
    @(negedge clk);
    clear_lanes();
    repeat (2) @(negedge clk);
    check("t3_count", 64'(fifo_count), 64'(16));
    check("t3_drops", 64'(drop_count), 64'(3));
    check("t3_valid", 64'(bus.trace_valid), 64'(1));
    check("t3_head_addr", 64'(bus.trace_address), 64'(24'h002000));
    bus.trace_ready = 1'b1;
    wait_drain("t3", 40);
    check("t3_drops_after", 64'(drop_count), 64'(3));

    // Reset mid-stream with 8 entries queued and a nonzero drop count.
    @(negedge clk);
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_lane(7, 24'h007000 + 24'(i), 32'h7700_0000 + 32'(i));
    end
    @(negedge clk);
    clear_lanes();
    @(negedge clk);
    check("t6_queued", 64'(fifo_count), 64'(8));
    check("t6_pre_drops", 64'(drop_count), 64'(3));
    reset_poweron = 1'b1;
    sb_q.delete();
    #1;
    check("t6_rst_valid", 64'(bus.trace_valid), 64'(0));
    check("t6_rst_count", 64'(fifo_count), 64'(0));
    check("t6_rst_drops", 64'(drop_count), 64'(0));
    check("t6_rst_addr", 64'(bus.trace_address), 64'(0));
    repeat (2) @(negedge clk);
    reset_poweron = 1'b0;
    set_lane(12, 24'h00ABCD, 32'h1234_5678);
    push_exp(12, 24'h00ABCD, 32'h1234_5678);
    @(negedge clk);
    clear_lanes();
    check("t6_not_yet_valid", 64'(bus.trace_valid), 64'(0));
    @(negedge clk);
    check("t6_valid", 64'(bus.trace_valid), 64'(1));
    check("t6_lane", 64'(bus.trace_lane), 64'(12));
    check("t6_count", 64'(fifo_count), 64'(1));
    bus.trace_ready = 1'b1;
    wait_drain("t6", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
